// File: rtl/expstate_irq_pkg.sv
// rtl/expstate_irq_pkg.sv - shared register map and FSM encoding for the export-state interrupt controller
package expstate_irq_pkg;

  localparam logic [1:0] ADDR_STATUS = 2'd0;
  localparam logic [1:0] ADDR_ENABLE = 2'd1;
  localparam logic [1:0] ADDR_RAW    = 2'd2;
  localparam logic [1:0] ADDR_CTRL   = 2'd3;

  localparam int CTRL_GEN = 0;

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_ASSERT  = 2'd1,
    S_HOLDOFF = 2'd2
  } irq_state_e;

endpackage

// File: rtl/expstate_edge_det.sv
// rtl/expstate_edge_det.sv - samples the export state and flags rising edges once armed after reset
module expstate_edge_det #(
  parameter int STATE_W = 32
) (
  input  logic               CLK,
  input  logic               BResetN,
  input  logic [STATE_W-1:0] i_state,
  output logic [STATE_W-1:0] o_state_q,
  output logic [STATE_W-1:0] o_rise
);

  logic [STATE_W-1:0] r_state_q;
  logic               r_armed;

  always_ff @(posedge CLK or negedge BResetN) begin
    if (!BResetN) begin
      r_state_q <= '0;
      r_armed   <= 1'b0;
    end else begin
      r_state_q <= i_state;
      r_armed   <= 1'b1;
    end
  end

  // Until the first post-reset sample, state_q is not a real history, so nothing counts as a rise.
  assign o_rise    = i_state & ~r_state_q & {STATE_W{r_armed}};
  assign o_state_q = r_state_q;

endmodule

// File: rtl/expstate_irq_ctrl.sv
// rtl/expstate_irq_ctrl.sv - latches export-state rises as events and drives a held-off level interrupt to core1
module expstate_irq_ctrl
  import expstate_irq_pkg::*;
#(
  parameter int STATE_W = 32,
  parameter int HOLDOFF = 4
) (
  input  logic               CLK,
  input  logic               BResetN,
  input  logic [STATE_W-1:0] TIE_EXPSTATE,
  input  logic               RegWr,
  input  logic               RegRd,
  input  logic [1:0]         RegAddr,
  input  logic [31:0]        RegWData,
  output logic [31:0]        RegRData,
  output logic               RegAck,
  output logic               BInterruptXX
);

  localparam int CNT_W = (HOLDOFF > 0) ? $clog2(HOLDOFF + 1) : 1;
  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'((HOLDOFF > 0) ? HOLDOFF - 1 : 0);

  logic [STATE_W-1:0] w_state_q;
  logic [STATE_W-1:0] w_rise;
  logic [STATE_W-1:0] w_clr;
  logic [31:0]        w_rd_val;
  logic               w_pend;

  logic [STATE_W-1:0] r_status;
  logic [STATE_W-1:0] r_enable;
  logic               r_gen;
  logic [31:0]        r_rdata;
  logic               r_ack;
  logic               r_irq;

  irq_state_e         r_state;
  irq_state_e         w_state_next;
  logic [CNT_W-1:0]   r_cnt;
  logic [CNT_W-1:0]   w_cnt_next;

  expstate_edge_det #(
    .STATE_W (STATE_W)
  ) u_edge_det (
    .CLK       (CLK),
    .BResetN   (BResetN),
    .i_state   (TIE_EXPSTATE),
    .o_state_q (w_state_q),
    .o_rise    (w_rise)
  );

  assign w_clr = (RegWr && (RegAddr == ADDR_STATUS)) ? RegWData[STATE_W-1:0] : '0;

  always_comb begin
    w_rd_val = '0;
    case (RegAddr)
      ADDR_STATUS: w_rd_val[STATE_W-1:0] = r_status;
      ADDR_ENABLE: w_rd_val[STATE_W-1:0] = r_enable;
      ADDR_RAW:    w_rd_val[STATE_W-1:0] = w_state_q;
      ADDR_CTRL:   w_rd_val[CTRL_GEN]    = r_gen;
      default:     w_rd_val              = '0;
    endcase
  end

  always_ff @(posedge CLK or negedge BResetN) begin
    if (!BResetN) begin
      r_status <= '0;
      r_enable <= '0;
      r_gen    <= 1'b0;
      r_rdata  <= '0;
      r_ack    <= 1'b0;
    end else begin
      // A new rise outranks a clear of the same bit, so no event is lost.
      r_status <= (r_status & ~w_clr) | w_rise;
      if (RegWr) begin
        case (RegAddr)
          ADDR_ENABLE: r_enable <= RegWData[STATE_W-1:0];
          ADDR_CTRL:   r_gen    <= RegWData[CTRL_GEN];
          default:     ;
        endcase
      end
      r_ack   <= RegWr | RegRd;
      r_rdata <= (RegRd && !RegWr) ? w_rd_val : '0;
    end
  end

  assign w_pend = r_gen & (|(r_status & r_enable));

  always_ff @(posedge CLK or negedge BResetN) begin
    if (!BResetN) begin
      r_state <= S_IDLE;
      r_cnt   <= '0;
      r_irq   <= 1'b0;
    end else begin
      r_state <= w_state_next;
      r_cnt   <= w_cnt_next;
      r_irq   <= (w_state_next == S_ASSERT);
    end
  end

  always_comb begin
    w_state_next = r_state;
    w_cnt_next   = r_cnt;
    case (r_state)
      S_IDLE: begin
        if (w_pend) w_state_next = S_ASSERT;
      end
      S_ASSERT: begin
        if (!w_pend) begin
          if (HOLDOFF == 0) begin
            w_state_next = S_IDLE;
          end else begin
            w_state_next = S_HOLDOFF;
            w_cnt_next   = CNT_LOAD;
          end
        end
      end
      S_HOLDOFF: begin
        // Leaving straight to ASSERT when an event is waiting keeps the low time at exactly HOLDOFF cycles.
        if (r_cnt == '0) begin
          w_state_next = w_pend ? S_ASSERT : S_IDLE;
        end else begin
          w_cnt_next = r_cnt - CNT_W'(1);
        end
      end
      default: begin
        w_state_next = S_IDLE;
        w_cnt_next   = '0;
      end
    endcase
  end

  assign RegRData     = r_rdata;
  assign RegAck       = r_ack;
  assign BInterruptXX = r_irq;

endmodule
